packet_loader: RTL and testbench

PACKET_LOADER -- requirements
Module: packet_loader

---
 rtl/packet_loader.sv | 177 +++++++++++++++++
 tb/tb_packet_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_loader.sv
// packet_loader: assembles a sync-framed, XOR-checked byte stream from a UART
// receiver into a shadow register bank and commits it atomically to regs_out.
// Frame: SYNC_BYTE, PAYLOAD_BYTES payload bytes (little-endian words, ascending
// word index), one checksum byte = XOR of all payload bytes.
module packet_loader #(
    parameter int unsigned NUM_WORDS   = 27,
    parameter int unsigned WORD_W      = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic [NUM_WORDS*WORD_W-1:0] regs_out,
    output logic                        frame_done,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int unsigned BANK_W        = NUM_WORDS * WORD_W;
    localparam int unsigned PAYLOAD_BYTES = BANK_W / 8;
    localparam int unsigned CNT_W         = $clog2(PAYLOAD_BYTES + 1);
    localparam int unsigned IDLE_W        = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
    localparam bit    TIMEOUT_EN          = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    byte_cnt;
    logic [7:0]          xor_acc;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [BANK_W-1:0]   shadow;
    logic [BANK_W-1:0]   regs_q;
    logic                frame_done_q;
    logic                frame_err_q;

    logic                is_sync;
    logic                timeout;
    logic                start;
    logic                load;
    logic                commit;
    logic                fail;

    // Shared decode: sync detection and mid-frame inactivity timeout.
    // A byte arriving in the same cycle as the timeout takes priority.
    always_comb begin
        is_sync = (rx_data == SYNC_BYTE);
        timeout = TIMEOUT_EN && (state != IDLE) && !rx_valid && (idle_cnt == IDLE_MAX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_valid && is_sync) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    if (byte_cnt == LAST_IDX) begin
                        state_nxt = CSUM;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            CSUM: begin
                if (rx_valid || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath-control decode.
    always_comb begin
        start  = 1'b0;
        load   = 1'b0;
        commit = 1'b0;
        fail   = 1'b0;
        busy   = (state != IDLE);
        case (state)
            IDLE: begin
                start = rx_valid && is_sync;
            end
            PAYLOAD: begin
                load = rx_valid;
                fail = timeout;
            end
            CSUM: begin
                commit = rx_valid && (rx_data == xor_acc);
                fail   = (rx_valid && (rx_data != xor_acc)) || timeout;
            end
            default: begin
                start = 1'b0;
            end
        endcase
    end

    // Byte counter and running checksum, restarted by each sync byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            xor_acc  <= '0;
        end else if (start) begin
            byte_cnt <= '0;
            xor_acc  <= '0;
        end else if (load) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            xor_acc  <= xor_acc ^ rx_data;
        end
    end

    // Shadow bank: payload byte n lands in bits [n*8 +: 8].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
                if (byte_cnt == CNT_W'(i)) begin
                    shadow[i*8 +: 8] <= rx_data;
                end
            end
        end
    end

    // Inactivity counter: cleared by any byte, held at zero while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!TIMEOUT_EN || rx_valid || state == IDLE || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Committed bank and status pulses; regs_out moves only on a good checksum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q       <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (commit) begin
                regs_q <= shadow;
            end
            frame_done_q <= commit;
            frame_err_q  <= fail;
        end
    end

    assign regs_out   = regs_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_packet_loader.sv
// Directed self-checking bench for packet_loader: a default-geometry instance
// (timeout shortened to 100 cycles) and a 3 x 24-bit instance.
module tb_packet_loader;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [431:0] regs_out;
    logic         frame_done;
    logic         frame_err;
    logic         busy;

    logic [7:0]   rx_data3;
    logic         rx_valid3;
    logic [71:0]  regs_out3;
    logic         frame_done3;
    logic         frame_err3;
    logic         busy3;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done3_cnt = 0;
    int err3_cnt = 0;
    int overlap = 0;
    int wait_cyc;

    logic [7:0]   pl [0:53];
    logic [431:0] exp_a;
    logic [431:0] exp_x;

    packet_loader #(
        .NUM_WORDS(27),
        .WORD_W(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYC(100)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .regs_out(regs_out),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .busy(busy)
    );

    packet_loader #(
        .NUM_WORDS(3),
        .WORD_W(24),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYC(100)
    ) u_dut3 (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data3),
        .rx_valid(rx_valid3),
        .regs_out(regs_out3),
        .frame_done(frame_done3),
        .frame_err(frame_err3),
        .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_err)   err_cnt++;
        if (frame_done3) done3_cnt++;
        if (frame_err3)  err3_cnt++;
        if ((frame_done && frame_err) || (frame_done3 && frame_err3)) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [431:0] obs, input logic [431:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the byte is taken on the next rising edge.
    task automatic send_byte(input logic sel, input logic [7:0] b);
        if (sel) begin
            rx_data3  = b;
            rx_valid3 = 1'b1;
        end else begin
            rx_data  = b;
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid  = 1'b0;
        rx_valid3 = 1'b0;
    endtask

    task automatic send_frame(input logic sel, input int unsigned n, input logic [7:0] csum);
        send_byte(sel, 8'hA5);
        for (int unsigned i = 0; i < n; i++) send_byte(sel, pl[i]);
        send_byte(sel, csum);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [431:0] pack54();
        logic [431:0] v;
        v = '0;
        for (int unsigned i = 0; i < 54; i++) v[i*8 +: 8] = pl[i];
        return v;
    endfunction

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rx_data3  = 8'h00;
        rx_valid3 = 1'b0;
        idle(3);

        chk("reset_regs", regs_out, '0);
        chk("reset_regs3", 432'(regs_out3), '0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_done", frame_done, 1'b0);
        chk_bit("reset_err", frame_err, 1'b0);
        chk_bit("reset_busy3", busy3, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Frame A: payload 0x00..0x35; XOR of 0x00..0x35 is 0x01.
        for (int i = 0; i < 54; i++) pl[i] = 8'(i);
        exp_a = pack54();
        send_frame(1'b0, 54, 8'h01);
        chk_bit("a_done_pulse", frame_done, 1'b1);
        chk_bit("a_no_err", frame_err, 1'b0);
        chk("a_word0", 432'(regs_out[0 +: 16]), 432'(16'h0100));
        chk("a_word26", 432'(regs_out[26*16 +: 16]), 432'(16'h3534));
        chk("a_regs", regs_out, exp_a);
        idle(1);
        chk_bit("a_done_one_cycle", frame_done, 1'b0);
        chk_bit("a_busy_after", busy, 1'b0);

        // Frame B: same payload, wrong checksum.
        send_frame(1'b0, 54, 8'h00);
        chk_bit("b_err_pulse", frame_err, 1'b1);
        chk_bit("b_no_done", frame_done, 1'b0);
        chk("b_regs_kept", regs_out, exp_a);
        idle(2);
        chk_int("b_done_cnt", done_cnt, 1);
        chk_int("b_err_cnt", err_cnt, 1);

        // Timeout: sync + 10 payload bytes, then silence.
        send_byte(1'b0, 8'hA5);
        for (int unsigned i = 0; i < 10; i++) send_byte(1'b0, pl[i]);
        chk_bit("to_busy_mid", busy, 1'b1);
        chk("to_regs_mid", regs_out, exp_a);
        wait_cyc = 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (frame_err) begin
                wait_cyc = j;
                break;
            end
        end
        // Counter reaches 100 after 100 idle edges; the error registers one edge later.
        chk_int("to_err_latency", wait_cyc, 101);
        chk_bit("to_busy_after", busy, 1'b0);
        chk("to_regs_kept", regs_out, exp_a);
        idle(2);
        chk_int("to_err_cnt", err_cnt, 2);

        // Frame C after timeout: payload 0xFF-n, checksum 0x01.
        for (int i = 0; i < 54; i++) pl[i] = 8'(255 - i);
        exp_x = pack54();
        send_frame(1'b0, 54, 8'h01);
        chk_bit("c_done_pulse", frame_done, 1'b1);
        chk("c_word0", 432'(regs_out[0 +: 16]), 432'(16'hFEFF));
        chk("c_regs", regs_out, exp_x);

        // Junk before sync is ignored; payload starting with A5 is data.
        idle(1);
        send_byte(1'b0, 8'h3C);
        send_byte(1'b0, 8'hFF);
        idle(2);
        chk_bit("junk_not_busy", busy, 1'b0);
        for (int i = 0; i < 54; i++) pl[i] = 8'(i) ^ 8'hA5;
        exp_x = pack54();
        send_frame(1'b0, 54, 8'h01);
        chk_bit("d_done_pulse", frame_done, 1'b1);
        chk("d_word0", 432'(regs_out[0 +: 16]), 432'(16'hA4A5));
        chk("d_regs", regs_out, exp_x);

        // Reset after payload byte 20.
        idle(1);
        for (int i = 0; i < 54; i++) pl[i] = 8'h80 | 8'(i);
        send_byte(1'b0, 8'hA5);
        for (int unsigned i = 0; i <= 20; i++) send_byte(1'b0, pl[i]);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("rst_regs", regs_out, '0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_no_err", frame_err, 1'b0);
        idle(2);
        chk_int("rst_err_cnt", err_cnt, 2);
        chk_int("rst_done_cnt", done_cnt, 3);
        send_frame(1'b0, 54, 8'h01);
        chk_bit("e_done_pulse", frame_done, 1'b1);
        chk("e_word0", 432'(regs_out[0 +: 16]), 432'(16'h8180));
        chk("e_word26", 432'(regs_out[26*16 +: 16]), 432'(16'hB5B4));
        idle(2);
        chk_int("e_done_cnt", done_cnt, 4);

        // 3 x 24-bit instance: two back-to-back frames.
        for (int i = 0; i < 9; i++) pl[i] = 8'h11 + 8'(i);
        send_frame(1'b1, 9, 8'h11);
        chk_bit("s1_done_pulse", frame_done3, 1'b1);
        chk("s1_regs", 432'(regs_out3), 432'(72'h191817_161514_131211));
        for (int i = 0; i < 9; i++) pl[i] = 8'h21 + 8'(i);
        send_frame(1'b1, 9, 8'h21);
        chk_bit("s2_done_pulse", frame_done3, 1'b1);
        chk("s2_regs", 432'(regs_out3), 432'(72'h292827_262524_232221));
        idle(2);
        chk_int("s_done_cnt", done3_cnt, 2);
        chk_int("s_err_cnt", err3_cnt, 0);
        chk_bit("s_busy_after", busy3, 1'b0);

        chk_int("done_err_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
